// File: rtl/two_digit_display_pkg.sv
// Shared constants for the two-digit 7-segment display driver: active-low segment
// patterns {g,f,e,d,c,b,a}, anode patterns {tens,ones}, and the digit-select encoding.
package two_digit_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } sel_e;

endpackage

// File: rtl/two_digit_display_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes 10-15 show a dash.
module bcd_to_seg7
    import two_digit_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/two_digit_display.sv
// Time-multiplexed two-digit common-anode display driver with per-frame input sampling.
// Optional LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module two_digit_display
    import two_digit_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       two_digit_display_clk,
    input  logic       two_digit_display_rst,
    input  logic [3:0] two_digit_display_first_num,
    input  logic [3:0] two_digit_display_second_num,
    output logic [6:0] two_digit_display_seg,
    output logic [1:0] two_digit_display_an,
    output logic       two_digit_display_dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    sel_e             sel_q, sel_d;
    logic [3:0]       shadow_ones_q, shadow_ones_d;
    logic [3:0]       shadow_tens_q, shadow_tens_d;
    logic [1:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             tick;
    logic [3:0]       dec_in;
    logic [6:0]       dec_out;

    assign tick = (presc_q == PRESC_LAST);

    // Leaving the tens slot means the next slot is a frame start: decode the live
    // ones input so the digit lit matches what is being latched on the same edge.
    always_comb begin
        dec_in = shadow_tens_q;
        if (sel_q == SEL_TENS) begin
            dec_in = two_digit_display_first_num;
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (dec_in),
        .seg (dec_out)
    );

    always_comb begin
        presc_d       = presc_q + CNT_W'(1);
        sel_d         = sel_q;
        shadow_ones_d = shadow_ones_q;
        shadow_tens_d = shadow_tens_q;
        an_d          = an_q;
        seg_d         = seg_q;
        if (tick) begin
            presc_d = '0;
            if (sel_q == SEL_TENS) begin
                sel_d         = SEL_ONES;
                shadow_ones_d = two_digit_display_first_num;
                shadow_tens_d = two_digit_display_second_num;
                an_d          = AN_ONES;
                seg_d         = dec_out;
            end else begin
                sel_d = SEL_TENS;
                an_d  = AN_TENS;
                seg_d = dec_out;
`ifdef LEADING_ZERO_BLANK_EN
                // Anode still pulses so overall brightness does not shift.
                if (shadow_tens_q == 4'd0) begin
                    seg_d = SEG_BLANK;
                end
`endif
            end
        end
    end

    always_ff @(posedge two_digit_display_clk or negedge two_digit_display_rst) begin
        if (!two_digit_display_rst) begin
            presc_q       <= '0;
            sel_q         <= SEL_ONES;
            shadow_ones_q <= 4'd0;
            shadow_tens_q <= 4'd0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
        end else begin
            presc_q       <= presc_d;
            sel_q         <= sel_d;
            shadow_ones_q <= shadow_ones_d;
            shadow_tens_q <= shadow_tens_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign two_digit_display_seg = seg_q;
    assign two_digit_display_an  = an_q;
    assign two_digit_display_dp  = 1'b1;

endmodule

// File: tb/tb_two_digit_display.sv
// Scoreboard bench for two_digit_display with REFRESH_DIV=4 and a 10 ns clock.
module tb_two_digit_display;

    localparam logic [6:0] S_0    = 7'b1000000;
    localparam logic [6:0] S_2    = 7'b0100100;
    localparam logic [6:0] S_3    = 7'b0110000;
    localparam logic [6:0] S_4    = 7'b0011001;
    localparam logic [6:0] S_5    = 7'b0010010;
    localparam logic [6:0] S_7    = 7'b1111000;
    localparam logic [6:0] S_9    = 7'b0010000;
    localparam logic [6:0] S_DASH = 7'b0111111;
    localparam logic [6:0] S_OFF  = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] S_TENS0 = S_OFF;
`else
    localparam logic [6:0] S_TENS0 = S_0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] first_num;
    logic [3:0] second_num;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;

    logic [9:0] exp_q[$];
    int         n_cmp;
    int         n_bad;
    logic [1:0] last_an;

    two_digit_display #(.REFRESH_DIV(4)) dut (
        .two_digit_display_clk        (clk),
        .two_digit_display_rst        (rst_n),
        .two_digit_display_first_num  (first_num),
        .two_digit_display_second_num (second_num),
        .two_digit_display_seg        (seg),
        .two_digit_display_an         (an),
        .two_digit_display_dp         (dp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic push_slot(input logic [1:0] a, input logic [6:0] s);
        exp_q.push_back({a, s, 1'b1});
    endtask

    task automatic check_now(input string name, input logic [9:0] act, input logic [9:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got an/seg/dp=%b required %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_dark(input string name, input int edges);
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            check_now(name, {an, seg, dp}, {2'b11, S_OFF, 1'b1});
        end
    endtask

    // monitor / scoreboard: every anode change to a lit digit is one presented output
    always @(negedge clk) begin
        if (!rst_n) begin
            last_an = 2'b11;
        end else if (an !== last_an) begin
            last_an = an;
            if (an !== 2'b11) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL slot_unexpected: got an/seg/dp=%b required nothing queued at %0t",
                             {an, seg, dp}, $time);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({an, seg, dp} !== e) begin
                        n_bad++;
                        $display("FAIL slot: got an/seg/dp=%b required %b at %0t",
                                 {an, seg, dp}, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        last_an    = 2'b11;
        rst_n      = 1'b0;
        first_num  = 4'd3;
        second_num = 4'd7;
        #12;
        check_now("reset_state", {an, seg, dp}, {2'b11, S_OFF, 1'b1});
        #8;
        rst_n = 1'b1;
        // first tick shows tens from the zeroed shadow, then frames with 3/7
        push_slot(2'b01, S_TENS0);
        push_slot(2'b10, S_3);
        push_slot(2'b01, S_7);
        push_slot(2'b10, S_3);
        check_dark("dark_after_release", 3);

        repeat (13) @(posedge clk);   // edge 16: ones slot just started
        #2;
        first_num = 4'd5;
        push_slot(2'b01, S_7);
        push_slot(2'b10, S_5);
        repeat (2) @(posedge clk);
        #1;
        check_now("ones_holds_midframe", {an, seg, dp}, {2'b10, S_3, 1'b1});

        repeat (7) @(posedge clk);    // edge 25
        #2;
        first_num = 4'd12;
        push_slot(2'b01, S_7);
        push_slot(2'b10, S_DASH);

        repeat (8) @(posedge clk);    // edge 33
        #2;
        first_num = 4'd9;
        push_slot(2'b01, S_7);
        push_slot(2'b10, S_9);

        repeat (8) @(posedge clk);    // edge 41
        #2;
        second_num = 4'd0;
        push_slot(2'b01, S_7);
        push_slot(2'b10, S_9);
        push_slot(2'b01, S_TENS0);

        repeat (12) @(posedge clk);   // edge 53: inside the tens slot
        #2;
        rst_n      = 1'b0;
        first_num  = 4'd4;
        second_num = 4'd2;
        #1;
        check_now("async_reset_midframe", {an, seg, dp}, {2'b11, S_OFF, 1'b1});
        #20;
        rst_n = 1'b1;
        push_slot(2'b01, S_TENS0);
        push_slot(2'b10, S_4);
        push_slot(2'b01, S_2);
        check_dark("dark_after_rerelease", 3);
        repeat (10) @(posedge clk);
        #1;

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL slots_pending: got %0d undelivered slots required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
